sec_countdown: RTL and testbench
================================

SEC_COUNTDOWN -- requirements
Module: sec_countdown

Interface
REQ-001 Parameter WIDTH, default 64, counter width in bits.
REQ-002 Parameter AUTO_RELOAD, default 0; 1 = a channel reloads its last loaded value on expiry.
REQ-003 Clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Slt  input  1  channel select: 0 = channel 0, 1 = channel 1; applies to Load and En.
REQ-006 En  input  1  decrement enable for the selected channel.
REQ-007 Load  input  1  load request for the selected channel.
REQ-008 Din  input  WIDTH  value for Load.
REQ-009 Output0  output  WIDTH  channel 0 current count.
REQ-010 Output1  output  WIDTH  channel 1 current count.
REQ-011 Done0  output  1  channel 0 expiry flag.
REQ-012 Done1  output  1  channel 1 expiry flag.

Function
REQ-013 Each channel SHALL hold its own state in {IDLE, RUN, DONE}, its count and its reload register.
REQ-014 Load with Slt=k SHALL, at the next edge, set OutputK=Din and reloadK=Din, clear DoneK, and enter RUN if Din!=0, otherwise DONE.
REQ-015 Load SHALL take priority over En in the same cycle; no decrement occurs that cycle.
REQ-016 In RUN, En=1 with Slt=k and Load=0 SHALL decrement OutputK by 1 at the next edge (latency 1 cycle).
REQ-017 A decrement from 1 to 0 with AUTO_RELOAD=0 SHALL set OutputK=0, enter DONE and assert DoneK as a level until the next Load of channel k.
REQ-018 A decrement from 1 with AUTO_RELOAD=1 SHALL instead set OutputK=reloadK, remain in RUN, and pulse DoneK high for exactly one cycle.
REQ-019 In IDLE or DONE, En SHALL be ignored; a count SHALL never wrap below 0.
REQ-020 The non-selected channel SHALL hold count, state and Done unchanged.
REQ-021 Din=0 loaded with AUTO_RELOAD=1 SHALL go to DONE with a DoneK level, never RUN (no zero-period reload).
REQ-022 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-023 Reset=1 SHALL immediately, asynchronously, force Output0=Output1=0, Done0=Done1=0, both reload registers=0 and both states=IDLE, regardless of Clk.
REQ-024 A Reset asserted mid-count SHALL discard the count; after release, only a fresh Load restarts a channel.
REQ-025 Load or En on the first edge after Reset deasserts SHALL take effect normally.

Structure
REQ-026 The state encoding (IDLE/RUN/DONE) and the default WIDTH constant SHALL live in a shared package, sec_counter_pkg.
REQ-027 One sub-module, countdown_channel, SHALL implement a single channel (parameters WIDTH and AUTO_RELOAD; inputs ld, dec and din; outputs count and done) and be instantiated twice, with Slt steering ld and dec.
REQ-028 The implementation SHALL be 120-400 lines of RTL in total.

Verification
REQ-029 Slt=0, Load, Din=3, then En=1 for 3 cycles -> Output0 steps 3,2,1,0; Done0 rises on the edge where Output0 becomes 0; Output1=0 throughout.
REQ-030 AUTO_RELOAD=1; Slt=1, Load, Din=2, then En=1 held -> Output1 steps 2,1,2,1,...; Done1 is a 1-cycle pulse on each 1->2 transition.
REQ-031 Load=1, En=1, Slt=0, Din=5 in the same cycle -> Output0=5 (no decrement); with AUTO_RELOAD=0, Load Din=0 -> Done0=1 and Output0 stays 0 under En.
REQ-032 Channel 0 loaded to 10 and channel 1 loaded to 4; toggle Slt every cycle with En=1 -> each channel decrements only in its selected cycles; the other holds.
REQ-033 Reset pulse between clock edges mid-count (Output0=7) -> Output0=0 and Done0=0 immediately; En after release leaves Output0=0.

Source files
------------

// File: rtl/sec_counter_pkg.sv
// Shared definitions for the two-channel countdown timer:
// per-channel state encoding and the default counter width.
package sec_counter_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_t;

endpackage

// File: rtl/countdown_channel.sv
// One countdown channel: load, decrement while running, and flag expiry.
// In auto-reload mode it restarts from the last loaded value instead of stopping.
module countdown_channel
    import sec_counter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             dec,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    chan_state_t      state;
    logic [WIDTH-1:0] reload;

    // NOTE: state uses non-blocking assignments; the reload register is reset
    // with the rest so a fresh Load is the only way back into RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else if (ld) begin
            count  <= din;
            reload <= din;
            // A zero load expires at once; it never enters RUN, even with auto-reload.
            if (din == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
            end else begin
                state <= ST_RUN;
                done  <= 1'b0;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    // In RUN, done is only ever the one-cycle auto-reload pulse.
                    done <= 1'b0;
                    if (dec) begin
                        if (count <= ONE) begin
                            if (AUTO_RELOAD) begin
                                count <= reload;
                                done  <= 1'b1;
                            end else begin
                                count <= '0;
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            count <= count - ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sec_countdown.sv
// Two-channel countdown timer; slt steers load and enable to one channel,
// the other channel holds its state.
module sec_countdown
    import sec_counter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slt,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] output0,
    output logic [WIDTH-1:0] output1,
    output logic             done0,
    output logic             done1
);

    logic ld0, ld1, dec0, dec1;

    // Load wins over enable, so a load cycle never also decrements.
    assign ld0  = load & ~slt;
    assign ld1  = load &  slt;
    assign dec0 = en & ~load & ~slt;
    assign dec1 = en & ~load &  slt;

    countdown_channel #(
        .WIDTH       (WIDTH),
        .AUTO_RELOAD (AUTO_RELOAD)
    ) u_ch0 (
        .clk   (clk),
        .reset (reset),
        .ld    (ld0),
        .dec   (dec0),
        .din   (din),
        .count (output0),
        .done  (done0)
    );

    countdown_channel #(
        .WIDTH       (WIDTH),
        .AUTO_RELOAD (AUTO_RELOAD)
    ) u_ch1 (
        .clk   (clk),
        .reset (reset),
        .ld    (ld1),
        .dec   (dec1),
        .din   (din),
        .count (output1),
        .done  (done1)
    );

endmodule

// File: tb/tb_sec_countdown.sv
// Bench for sec_countdown: one instance per reload mode, a behavioural model
// compared every cycle, plus directed literal checks of the key scenarios.
module tb_sec_countdown;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         slt = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0] out0 [2];
    logic [W-1:0] out1 [2];
    logic         dn0  [2];
    logic         dn1  [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sec_countdown #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_a (
        .clk(clk), .reset(reset), .slt(slt), .en(en), .load(load), .din(din),
        .output0(out0[0]), .output1(out1[0]), .done0(dn0[0]), .done1(dn1[0])
    );

    sec_countdown #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_b (
        .clk(clk), .reset(reset), .slt(slt), .en(en), .load(load), .din(din),
        .output0(out0[1]), .output1(out1[1]), .done0(dn0[1]), .done1(dn1[1])
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index [mode][channel], mode 1 = auto-reload.
    logic [W-1:0] m_cnt [2][2];
    logic [W-1:0] m_rld [2][2];
    bit           m_act [2][2];
    bit           m_dn  [2][2];

    always @(posedge clk or posedge reset) begin
        for (int a = 0; a < 2; a++) begin
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    m_cnt[a][k] = '0;
                    m_rld[a][k] = '0;
                    m_act[a][k] = 1'b0;
                    m_dn[a][k]  = 1'b0;
                end else if (int'(slt) == k && load) begin
                    m_cnt[a][k] = din;
                    m_rld[a][k] = din;
                    m_act[a][k] = (din != 0);
                    m_dn[a][k]  = (din == 0);
                end else if (m_act[a][k]) begin
                    m_dn[a][k] = 1'b0;
                    if (int'(slt) == k && en) begin
                        if (m_cnt[a][k] == 1) begin
                            m_dn[a][k] = 1'b1;
                            if (a == 1) m_cnt[a][k] = m_rld[a][k];
                            else begin
                                m_cnt[a][k] = 0;
                                m_act[a][k] = 1'b0;
                            end
                        end else begin
                            m_cnt[a][k] = m_cnt[a][k] - 1;
                        end
                    end
                end
            end
        end
    end

    // Continuous compare, away from the active edge.
    always @(negedge clk) begin
        for (int a = 0; a < 2; a++) begin
            check($sformatf("mode%0d output0", a), out0[a], m_cnt[a][0]);
            check($sformatf("mode%0d output1", a), out1[a], m_cnt[a][1]);
            check($sformatf("mode%0d done0", a), W'(dn0[a]), W'(m_dn[a][0]));
            check($sformatf("mode%0d done1", a), W'(dn1[a]), W'(m_dn[a][1]));
        end
    end

    task automatic cyc(input bit s, input bit e, input bit l, input logic [W-1:0] d);
        slt = s; en = e; load = l; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset output0", out0[0], 0);
        check("reset done1 ar", W'(dn1[1]), 0);
        reset = 1'b0;

        // Load 3 then count down to expiry with no reload.
        cyc(0, 0, 1, 3);
        check("ld3 output0", out0[0], 3);
        cyc(0, 1, 0, 0); check("dec output0=2", out0[0], 2);
        cyc(0, 1, 0, 0); check("dec output0=1", out0[0], 1);
        check("done0 low before expiry", W'(dn0[0]), 0);
        cyc(0, 1, 0, 0); check("dec output0=0", out0[0], 0);
        check("done0 on expiry", W'(dn0[0]), 1);
        check("output1 untouched", out1[0], 0);
        cyc(0, 1, 0, 0); check("no wrap below 0", out0[0], 0);

        // Auto-reload channel 1 with period 2.
        cyc(1, 0, 1, 2); check("ar ld2 output1", out1[1], 2);
        cyc(1, 1, 0, 0); check("ar output1=1", out1[1], 1);
        cyc(1, 1, 0, 0); check("ar reload output1=2", out1[1], 2);
        check("ar done1 pulse", W'(dn1[1]), 1);
        cyc(1, 1, 0, 0); check("ar output1=1 again", out1[1], 1);
        check("ar done1 pulse ends", W'(dn1[1]), 0);
        cyc(1, 1, 0, 0); check("ar second pulse", W'(dn1[1]), 1);

        // Load beats enable; zero load expires immediately.
        cyc(0, 1, 1, 5); check("load priority", out0[0], 5);
        cyc(0, 0, 1, 0); check("zero load done0", W'(dn0[0]), 1);
        check("ar zero load done0", W'(dn0[1]), 1);
        cyc(0, 1, 0, 0); check("zero load stays 0", out0[0], 0);
        check("ar zero load no reload", out0[1], 0);

        // Alternating select: each channel only moves in its own cycles.
        cyc(0, 0, 1, 10);
        cyc(1, 0, 1, 4);
        cyc(0, 1, 0, 0); check("alt a0", out0[0], 9); check("alt a1", out1[0], 4);
        cyc(1, 1, 0, 0); check("alt b0", out0[0], 9); check("alt b1", out1[0], 3);
        cyc(0, 1, 0, 0); check("alt c0", out0[0], 8);
        cyc(1, 1, 0, 0); check("alt d1", out1[0], 2);

        // Asynchronous reset between edges mid-count.
        cyc(0, 0, 1, 9);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0); check("pre-reset output0", out0[0], 7);
        #2 reset = 1'b1;
        #1;
        check("async reset output0", out0[0], 0);
        check("async reset done0", W'(dn0[0]), 0);
        check("async reset output1 ar", out1[1], 0);
        reset = 1'b0;
        cyc(0, 1, 0, 0); check("en after reset ignored", out0[0], 0);
        cyc(1, 0, 1, 6); check("load after reset", out1[0], 6);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] d;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
            d = ($urandom_range(0, 15) == 0) ? {$urandom(), $urandom()} : W'($urandom_range(0, 6));
            cyc(1'($urandom()), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, d);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
